// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard ASCII receive FIFO.
package kbd_pkg;

  localparam int KBD_FIFO_DEPTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } cap_state_t;

endpackage

// File: rtl/kbd_sync_fifo.sv
// Single-clock show-ahead FIFO; data holds the head entry, or the last popped value when empty.
module kbd_sync_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = KBD_FIFO_DEPTH,
  parameter int WIDTH = 7,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  // A pop frees the head slot this cycle, so a push into a full FIFO is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (do_pop) rd_ptr_nxt = rd_ptr + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: the storage array has no reset; the occupancy count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      data   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      full   <= (count_nxt == FULL_CNT);
      empty  <= (count_nxt == '0);
      // The new head is the word being written when it lands in the slot the head now points at.
      if (count_nxt != '0) begin
        if (do_push && (rd_ptr_nxt == wr_ptr)) data <= wdata;
        else                                    data <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/kbd_ascii_fifo.sv
// Keyboard ASCII capture: two-state handshake with the front end feeding a CPU-side FIFO.
module kbd_ascii_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = KBD_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [6:0]               ascii_code,
  input  logic                     ascii_data_ready,
  output logic                     rx_ascii_read,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic                     irq
);

  cap_state_t state;
  logic       push_req;
  logic       drop;
  logic [6:0] head;

  assign push_req = (state == IDLE) && ascii_data_ready;
  // Mirrors the FIFO's own acceptance rule: full with no same-cycle pop loses the character.
  assign drop     = push_req && full && !(rd_en && !empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rx_ascii_read <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ascii_data_ready) begin
            state         <= ACK;
            rx_ascii_read <= 1'b1;
          end
        end
        ACK: begin
          state         <= IDLE;
          rx_ascii_read <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          rx_ascii_read <= 1'b0;
        end
      endcase
    end
  end

  // A drop in the same cycle wins over the clear so no overflow event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  kbd_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (7)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (rd_en),
    .wdata (ascii_code),
    .data  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign rd_data = {1'b0, head};
  assign irq     = ~empty;

endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// Scoreboard bench for kbd_ascii_fifo: expected characters queued at capture, compared as popped.
module tb_kbd_ascii_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    ascii_code;
  logic          ascii_data_ready;
  logic          rx_ascii_read;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_ovf;
  logic          irq;

  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] sb[$];
  logic [6:0] last_out;
  logic       ovf_exp;

  always #5 clk = ~clk;

  kbd_ascii_fifo #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .ascii_code       (ascii_code),
    .ascii_data_ready (ascii_data_ready),
    .rx_ascii_read    (rx_ascii_read),
    .rd_en            (rd_en),
    .rd_data          (rd_data),
    .empty            (empty),
    .full             (full),
    .count            (count),
    .overflow         (overflow),
    .clr_ovf          (clr_ovf),
    .irq              (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_rd;
    int         n;
    n = sb.size();
    if (n > 0) exp_rd = {1'b0, sb[0]};
    else       exp_rd = {1'b0, last_out};
    check({tag, "/count"},    count,    n);
    check({tag, "/empty"},    empty,    (n == 0));
    check({tag, "/full"},     full,     (n == DEPTH));
    check({tag, "/irq"},      irq,      (n != 0));
    check({tag, "/overflow"}, overflow, ovf_exp);
    check({tag, "/rd_data"},  rd_data,  exp_rd);
  endtask

  // Front-end model: raise ready, wait (bounded) for the ack, drop ready on the next edge.
  task automatic send_char(input logic [6:0] code, input logic with_pop);
    int pre;
    bit popping;
    bit got_ack;
    pre     = sb.size();
    popping = with_pop && (pre > 0);
    if (popping) begin
      check("pop_head", rd_data, {1'b0, sb[0]});
      last_out = sb.pop_front();
    end
    if (pre < DEPTH || popping) sb.push_back(code);
    else                        ovf_exp = 1'b1;
    ascii_code       = code;
    ascii_data_ready = 1'b1;
    rd_en            = with_pop;
    got_ack          = 1'b0;
    for (int i = 0; i < 4 && !got_ack; i++) begin
      @(negedge clk);
      rd_en   = 1'b0;
      got_ack = rx_ascii_read;
    end
    check("ack", got_ack, 1);
    ascii_data_ready = 1'b0;
    check_state("capture");
    @(negedge clk);
    check("ack_one_cycle", rx_ascii_read, 0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      if (sb.size() > 0) begin
        check("pop_head", rd_data, {1'b0, sb[0]});
        last_out = sb.pop_front();
      end
      rd_en = 1'b1;
      @(negedge clk);
    end
    rd_en = 1'b0;
    check_state("after_pop");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    ascii_code       = '0;
    ascii_data_ready = 1'b0;
    rd_en            = 1'b0;
    clr_ovf          = 1'b0;
    last_out         = '0;
    ovf_exp          = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset");
    check("reset/ack", rx_ascii_read, 0);
    rst = 1'b0;

    // Single character, 1-cycle latency to rd_data
    send_char(7'h41, 1'b0);
    pop_n(1);

    // Pop on empty is ignored and rd_data holds the last popped value
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check_state("pop_empty");

    // Fill to full, drain in order
    for (int i = 0; i < DEPTH; i++) send_char(7'(8'h30 + i), 1'b0);
    check("fill/full", full, 1);
    pop_n(DEPTH);

    // Overflow on full, then clear
    for (int i = 0; i < DEPTH; i++) send_char(7'(8'h50 + i), 1'b0);
    send_char(7'h7A, 1'b0);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    ovf_exp = 1'b0;
    check_state("clr_ovf");

    // Overflow event beats a same-cycle clear
    clr_ovf = 1'b1;
    send_char(7'h7B, 1'b0);
    clr_ovf = 1'b0;
    ovf_exp = 1'b0;
    check_state("ovf_priority_then_clear");

    // Push with same-cycle pop while full
    send_char(7'h61, 1'b1);
    pop_n(DEPTH);
    check("last_out_is_61", rd_data, 8'h61);

    // Async reset in ACK, then a held ready is captured again
    for (int i = 0; i < DEPTH; i++) send_char(7'(8'h20 + i), 1'b0);
    send_char(7'h7E, 1'b0);
    ascii_code       = 7'h2A;
    ascii_data_ready = 1'b1;
    @(negedge clk);
    check("pre_rst/ack", rx_ascii_read, 1);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    last_out = '0;
    ovf_exp  = 1'b0;
    check_state("async_rst");
    check("async_rst/ack", rx_ascii_read, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb.push_back(7'h2A);
    check("recapture/ack", rx_ascii_read, 1);
    check_state("recapture");
    ascii_data_ready = 1'b0;
    @(negedge clk);
    check("recapture/ack_one_cycle", rx_ascii_read, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
